// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Memory-stage controller between the EXE/MEM pipeline register and an
//   external 16-bit asynchronous SRAM. A 32-bit load or store becomes two
//   16-bit SRAM accesses: the low half first, then the high half. Each half
//   lasts ACCESS_CYCLES clocks. ready is held low for the whole access and
//   is used upstream as the pipeline freeze (~ready).
//
// Ports
//   clk, rst            system clock, synchronous active-low reset
//   MEM_r_en, MEM_w_en  load / store request (level, held until ready)
//   address             32-bit byte address
//   write_data          32-bit store data
//   read_data           32-bit load result (valid from DONE onward)
//   ready               1 = idle with no request, or access completing
//   SRAM_DQ             16-bit bidirectional SRAM data bus
//   SRAM_ADDR           SRAM half-word address
//   SRAM_WE_N           SRAM write strobe, active low
//   SRAM_UB_N/LB_N/CE_N/OE_N  tied active (0)
module sram_mem_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int SRAM_AW       = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_r_en,
    input  logic               MEM_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int         WORD_W   = SRAM_AW - 1;
    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         offset;
    logic [WORD_W-1:0]   req_word;
    logic                last_cyc;
    logic                dq_drive;
    logic [15:0]         dq_out;

    // Word index wraps modulo the SRAM size; no range check.
    assign offset   = address - 32'(BASE_ADDR);
    assign req_word = WORD_W'(offset >> 2);
    assign last_cyc = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                // Store wins when both requests are present.
                if (MEM_w_en) begin
                    word_d  = req_word;
                    wdata_d = write_data;
                    state_d = WR_LO;
                end else if (MEM_r_en) begin
                    word_d  = req_word;
                    state_d = RD_LO;
                end
            end
            RD_LO, RD_HI, WR_LO, WR_HI: begin
                if (last_cyc) begin
                    cnt_d = 4'd0;
                    case (state_q)
                        RD_LO: begin
                            rdata_d[15:0] = SRAM_DQ;
                            state_d       = RD_HI;
                        end
                        RD_HI: begin
                            rdata_d[31:16] = SRAM_DQ;
                            state_d        = DONE;
                        end
                        WR_LO:   state_d = WR_HI;
                        default: state_d = DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = ((state_q == IDLE) && !MEM_r_en && !MEM_w_en) || (state_q == DONE);
        SRAM_ADDR = '0;
        dq_drive  = 1'b0;
        dq_out    = wdata_q[15:0];
        case (state_q)
            RD_LO: SRAM_ADDR = {word_q, 1'b0};
            RD_HI: SRAM_ADDR = {word_q, 1'b1};
            WR_LO: begin
                SRAM_ADDR = {word_q, 1'b0};
                dq_drive  = 1'b1;
            end
            WR_HI: begin
                SRAM_ADDR = {word_q, 1'b1};
                dq_drive  = 1'b1;
                dq_out    = wdata_q[31:16];
            end
            default: ;
        endcase
    end

    assign SRAM_WE_N = ~dq_drive;
    assign SRAM_DQ   = dq_drive ? dq_out : 16'hzzzz;
    assign read_data = rdata_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            word_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;

    // Default build (ACCESS_CYCLES=2)
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

    // ACCESS_CYCLES=1 build
    logic        r1_en = 1'b0;
    logic        w1_en = 1'b0;
    logic [31:0] addr1_in = 32'd0;
    logic [31:0] wdata1 = 32'd0;
    logic [31:0] rd1;
    logic        rdy1;
    wire  [15:0] dq1;
    logic [17:0] sram_addr1;
    logic        we1_n, ub1_n, lb1_n, ce1_n, oe1_n;

    logic [15:0] mem [0:63];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_mem_controller dut (
        .clk(clk), .rst(rst), .MEM_r_en(mem_r_en), .MEM_w_en(mem_w_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
        .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
    );

    sram_mem_controller #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_r_en(r1_en), .MEM_w_en(w1_en),
        .address(addr1_in), .write_data(wdata1), .read_data(rd1),
        .ready(rdy1), .SRAM_DQ(dq1), .SRAM_ADDR(sram_addr1),
        .SRAM_WE_N(we1_n), .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n),
        .SRAM_CE_N(ce1_n), .SRAM_OE_N(oe1_n)
    );

    // Behavioural SRAM: async read, write captured while WE_N is low.
    // Word 0 holds a known marker so an idle bus has a recognisable value.
    always @(posedge clk) begin
        if (!rst) mem[0] <= 16'hC3C3;
        else if (!sram_we_n && !sram_ce_n) mem[sram_addr[5:0]] <= sram_dq;
    end
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;

    // Second SRAM returns an address-derived pattern.
    assign dq1 = (!oe1_n && we1_n) ? (sram_addr1[15:0] ^ 16'h5A00) : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full access on the default build; called at #1 after an edge
    // and returns at #1 after the edge that leaves DONE.
    task automatic run_xfer(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd, input string nm);
        logic [16:0] wd;
        logic        busy, hi;
        wd = 17'((a - 32'd1024) >> 2);
        mem_r_en = r; mem_w_en = w; address = a; write_data = d;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            busy = (c >= 1) && (c <= 4);
            hi   = (c >= 3);
            chk({nm, "_ready"}, 32'(ready), 32'(c == 5));
            chk({nm, "_we_n"}, 32'(sram_we_n), 32'(!(w && busy)));
            chk({nm, "_addr"}, 32'(sram_addr), busy ? 32'({wd, hi}) : 32'd0);
            if (w && busy) chk({nm, "_dq"}, 32'(sram_dq), hi ? 32'(d[31:16]) : 32'(d[15:0]));
            if (c == 5) chk({nm, "_rdata"}, read_data, exp_rd);
            @(posedge clk); #1;
            // New address/data while busy must be ignored.
            if (c == 1) begin address = 32'h0000_0000; write_data = 32'h5555_5555; end
        end
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_rdata", read_data, 32'd0);
            chk("idle_addr", 32'(sram_addr), 32'd0);
            chk("idle_dq_released", 32'(sram_dq), 32'h0000C3C3);
        end
        chk("tie_offs", {28'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 32'd0);
        chk("tie_offs1", {28'd0, ub1_n, lb1_n, ce1_n, oe1_n}, 32'd0);
        @(posedge clk); #1;

        // Store 0xDEADBEEF to 1032 (word 2, halves 4/5), then load it back
        run_xfer(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd0, "st1");
        chk("mem4", 32'(mem[4]), 32'h0000BEEF);
        chk("mem5", 32'(mem[5]), 32'h0000DEAD);
        run_xfer(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, "ld1");

        // Both requests high: store wins (1040 -> word 4, halves 8/9)
        run_xfer(1'b1, 1'b1, 32'd1040, 32'h12345678, 32'hDEADBEEF, "both");
        chk("mem8", 32'(mem[8]), 32'h00005678);
        chk("mem9", 32'(mem[9]), 32'h00001234);
        run_xfer(1'b1, 1'b0, 32'd1040, 32'd0, 32'h12345678, "ld2");

        // Back-to-back load then store; second call's cycle 0 is the idle gap
        start = cyc;
        run_xfer(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, "b2b_ld");
        run_xfer(1'b0, 1'b1, 32'd1048, 32'hCAFEF00D, 32'hDEADBEEF, "b2b_st");
        chk("b2b_cycles", 32'(cyc - start), 32'd12);
        chk("mem12", 32'(mem[12]), 32'h0000F00D);
        chk("mem13", 32'(mem[13]), 32'h0000CAFE);

        // Reset during WR_HI (1056 -> word 8, halves 16/17)
        mem_w_en = 1'b1; address = 32'd1056; write_data = 32'h0BADF00D;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_pre_we_n", 32'(sram_we_n), 32'd0);
        chk("rst_pre_addr", 32'(sram_addr), 32'd17);
        rst = 1'b0; mem_w_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_dq_released", 32'(sram_dq), 32'h0000C3C3);
        @(posedge clk); #1;
        run_xfer(1'b1, 1'b0, 32'd1040, 32'd0, 32'h12345678, "ld_after_rst");

        // ACCESS_CYCLES=1: load 1036 (word 3, halves 6/7), ready in cycle 3
        r1_en = 1'b1; addr1_in = 32'd1036;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk("ac1_ready", 32'(rdy1), 32'(c == 3));
            chk("ac1_we_n", 32'(we1_n), 32'd1);
            if (c == 1) chk("ac1_addr_lo", 32'(sram_addr1), 32'd6);
            if (c == 2) chk("ac1_addr_hi", 32'(sram_addr1), 32'd7);
            if (c == 3) chk("ac1_rdata", rd1, 32'h5A075A06);
            @(posedge clk); #1;
        end
        r1_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
